// File: rtl/ifu_iccm_pkg.sv
// Shared types and helpers for the ICCM fetch/DMA arbiter.
package ifu_iccm_pkg;

  localparam int ICCM_WORD_BYTES = 8;
  localparam int DMA_TAG_W_MAX   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2,
    HOLD  = 2'd3
  } iccm_arb_state_t;

  // One buffered DMA request; tag is stored at its maximum width and
  // sliced down to the configured width by the user.
  typedef struct packed {
    logic                     wr;
    logic [31:0]              addr;
    logic [63:0]              wdata;
    logic [DMA_TAG_W_MAX-1:0] tag;
    logic                     err;
  } dma_req_t;

  // Access error: address outside [sadr, sadr + 2**aw) or not 8B aligned.
  // The range is evaluated on 33 bits so a window ending at 4 GiB works.
  function automatic logic iccm_dma_addr_err(input logic [31:0] addr,
                                             input logic [31:0] sadr,
                                             input int unsigned aw);
    logic [32:0] lo;
    logic [32:0] hi;
    logic [32:0] a;
    logic        misaligned;
    lo = {1'b0, sadr};
    hi = lo + (33'd1 << aw);
    a  = {1'b0, addr};
    misaligned = (addr & 32'(ICCM_WORD_BYTES - 1)) != 32'd0;
    return (a < lo) | (a >= hi) | misaligned;
  endfunction

endpackage

// File: rtl/ifu_iccm_dma_buf.sv
// Single-entry DMA request buffer; classifies the request as good or
// erroneous at accept time so the grant path only reads a flag.
module ifu_iccm_dma_buf
  import ifu_iccm_pkg::*;
#(
  parameter logic [31:0] ICCM_SADR = 32'hEE000000,
  parameter int          ICCM_AW   = 16,
  parameter int          TAG_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_accept,
  input  logic             i_gnt,
  input  logic             i_wr,
  input  logic [31:0]      i_addr,
  input  logic [63:0]      i_wdata,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  output dma_req_t         o_req
);

  logic     r_valid;
  dma_req_t r_req;
  dma_req_t w_req;

  // Pack the incoming request and tag it with its error status.
  always_comb begin
    w_req       = '0;
    w_req.wr    = i_wr;
    w_req.addr  = i_addr;
    w_req.wdata = i_wdata;
    w_req.tag   = DMA_TAG_W_MAX'(i_tag);
    w_req.err   = iccm_dma_addr_err(i_addr, ICCM_SADR, ICCM_AW);
  end

  // Load on accept (a grant in the same cycle frees the old entry); drain on grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_req   <= '0;
    end else if (i_accept) begin
      r_valid <= 1'b1;
      r_req   <= w_req;
    end else if (i_gnt) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_req   = r_req;

endmodule

// File: rtl/ifu_iccm_dma_arb.sv
// ICCM port arbiter: fetch owns the SRAM unless a buffered DMA request is
// granted; a starving DMA request raises a fetch stall until it is served.
module ifu_iccm_dma_arb
  import ifu_iccm_pkg::*;
#(
  parameter logic [31:0] ICCM_SADR  = 32'hEE000000,
  parameter int          ICCM_AW    = 16,
  parameter int          TAG_W      = 3,
  parameter int          STARVE_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ifc_fetch_req_f1,
  input  logic               ifc_iccm_access_f1,
  input  logic [31:1]        ifc_fetch_addr_f1,
  input  logic               ifc_dma_access_ok,
  input  logic               dma_iccm_req,
  input  logic               dma_iccm_wr,
  input  logic [31:0]        dma_iccm_addr,
  input  logic [63:0]        dma_iccm_wdata,
  input  logic [TAG_W-1:0]   dma_iccm_tag,
  output logic               dma_iccm_ready,
  output logic               dma_iccm_stall_any,
  output logic               iccm_rden,
  output logic               iccm_wren,
  output logic [ICCM_AW-4:0] iccm_addr,
  output logic [63:0]        iccm_wdata,
  input  logic [63:0]        iccm_rd_data,
  output logic               dma_iccm_rvalid,
  output logic [TAG_W-1:0]   dma_iccm_rtag,
  output logic [63:0]        dma_iccm_rdata,
  output logic               dma_iccm_err
);

  localparam logic [3:0] CNT_LAST = 4'(STARVE_MAX - 1);

  iccm_arb_state_t r_state;
  logic [3:0]      r_cnt;
  logic            r_stall;
  logic            r_rvalid;
  logic            r_rerr;
  logic [TAG_W-1:0] r_rtag;

  logic     w_buf_valid;
  dma_req_t w_buf;
  logic     w_gnt;
  logic     w_accept;
  logic     w_rsp;
  logic     w_unused_ok;

  assign w_gnt          = w_buf_valid & ifc_dma_access_ok & (r_state != IDLE);
  assign dma_iccm_ready = ~w_buf_valid | w_gnt;
  assign w_accept       = dma_iccm_req & dma_iccm_ready;
  // Reads and erroneous requests (reads or writes) produce a response.
  assign w_rsp          = w_gnt & (w_buf.err | ~w_buf.wr);

  ifu_iccm_dma_buf #(
    .ICCM_SADR (ICCM_SADR),
    .ICCM_AW   (ICCM_AW),
    .TAG_W     (TAG_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .i_accept (w_accept),
    .i_gnt    (w_gnt),
    .i_wr     (dma_iccm_wr),
    .i_addr   (dma_iccm_addr),
    .i_wdata  (dma_iccm_wdata),
    .i_tag    (dma_iccm_tag),
    .o_valid  (w_buf_valid),
    .o_req    (w_buf)
  );

  // SRAM port mux: a DMA grant takes the port; an erroneous entry never touches the array.
  always_comb begin
    iccm_rden  = ifc_fetch_req_f1 & ifc_iccm_access_f1;
    iccm_wren  = 1'b0;
    iccm_addr  = ifc_fetch_addr_f1[ICCM_AW-1:3];
    iccm_wdata = 64'd0;
    if (w_gnt) begin
      iccm_rden  = ~w_buf.err & ~w_buf.wr;
      iccm_wren  = ~w_buf.err & w_buf.wr;
      iccm_addr  = w_buf.addr[ICCM_AW-1:3];
      iccm_wdata = w_buf.wdata;
    end else begin
      iccm_wren  = 1'b0;
    end
  end

  // Starvation FSM with saturating wait counter and registered stall request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_stall <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt   <= 4'd0;
          r_stall <= 1'b0;
          if (w_accept) begin
            r_state <= PEND;
          end
        end
        PEND: begin
          if (w_gnt) begin
            r_state <= w_accept ? PEND : IDLE;
            r_cnt   <= 4'd0;
            r_stall <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= FORCE;
            r_stall <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + 4'd1;
          end
        end
        FORCE, HOLD: begin
          if (w_gnt) begin
            r_state <= w_accept ? PEND : IDLE;
            r_cnt   <= 4'd0;
            r_stall <= 1'b0;
          end else begin
            r_state <= HOLD;
            r_stall <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 4'd0;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  // Response stage: one cycle after the grant, aligned with SRAM read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rerr   <= 1'b0;
      r_rtag   <= '0;
    end else begin
      r_rvalid <= w_rsp;
      r_rerr   <= w_rsp & w_buf.err;
      r_rtag   <= w_rsp ? w_buf.tag[TAG_W-1:0] : '0;
    end
  end

  assign dma_iccm_stall_any = r_stall;
  assign dma_iccm_rvalid    = r_rvalid;
  assign dma_iccm_err       = r_rerr;
  assign dma_iccm_rtag      = r_rtag;
  assign dma_iccm_rdata     = (r_rvalid & ~r_rerr) ? iccm_rd_data : 64'd0;

  // Address bits outside the word index and spare tag bits are intentionally unused.
  assign w_unused_ok = ^{w_buf.addr, w_buf.tag};

endmodule

// File: tb/tb_ifu_iccm_dma_arb.sv
// Directed bench for the ICCM fetch/DMA arbiter.
module tb_ifu_iccm_dma_arb;

  localparam logic [31:0] SADR = 32'hEE000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifc_fetch_req_f1;
  logic        ifc_iccm_access_f1;
  logic [31:1] ifc_fetch_addr_f1;
  logic        ifc_dma_access_ok;
  logic        dma_iccm_req;
  logic        dma_iccm_wr;
  logic [31:0] dma_iccm_addr;
  logic [63:0] dma_iccm_wdata;
  logic [2:0]  dma_iccm_tag;
  logic        dma_iccm_ready;
  logic        dma_iccm_stall_any;
  logic        iccm_rden;
  logic        iccm_wren;
  logic [12:0] iccm_addr;
  logic [63:0] iccm_wdata;
  logic [63:0] iccm_rd_data;
  logic        dma_iccm_rvalid;
  logic [2:0]  dma_iccm_rtag;
  logic [63:0] dma_iccm_rdata;
  logic        dma_iccm_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ifu_iccm_dma_arb dut (
    .clk                (clk),
    .rst                (rst),
    .ifc_fetch_req_f1   (ifc_fetch_req_f1),
    .ifc_iccm_access_f1 (ifc_iccm_access_f1),
    .ifc_fetch_addr_f1  (ifc_fetch_addr_f1),
    .ifc_dma_access_ok  (ifc_dma_access_ok),
    .dma_iccm_req       (dma_iccm_req),
    .dma_iccm_wr        (dma_iccm_wr),
    .dma_iccm_addr      (dma_iccm_addr),
    .dma_iccm_wdata     (dma_iccm_wdata),
    .dma_iccm_tag       (dma_iccm_tag),
    .dma_iccm_ready     (dma_iccm_ready),
    .dma_iccm_stall_any (dma_iccm_stall_any),
    .iccm_rden          (iccm_rden),
    .iccm_wren          (iccm_wren),
    .iccm_addr          (iccm_addr),
    .iccm_wdata         (iccm_wdata),
    .iccm_rd_data       (iccm_rd_data),
    .dma_iccm_rvalid    (dma_iccm_rvalid),
    .dma_iccm_rtag      (dma_iccm_rtag),
    .dma_iccm_rdata     (dma_iccm_rdata),
    .dma_iccm_err       (dma_iccm_err)
  );

  // SRAM model: word idx reads back as DA7A0000_00000000 + idx, one cycle after rden.
  always @(posedge clk) begin
    if (iccm_rden) iccm_rd_data <= {32'hDA7A0000, 19'd0, iccm_addr};
    else           iccm_rd_data <= 64'hFFFF_FFFF_FFFF_FFFF;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dma_drive(input logic req, input logic wr, input logic [31:0] addr,
                           input logic [63:0] wd, input logic [2:0] tag);
    dma_iccm_req   = req;
    dma_iccm_wr    = wr;
    dma_iccm_addr  = addr;
    dma_iccm_wdata = wd;
    dma_iccm_tag   = tag;
  endtask

  task automatic fetch_drive(input logic req, input logic [31:0] byte_addr);
    ifc_fetch_req_f1   = req;
    ifc_iccm_access_f1 = req;
    ifc_fetch_addr_f1  = byte_addr[31:1];
  endtask

  initial begin
    iccm_rd_data = 64'd0;
    rst = 1'b1;
    ifc_dma_access_ok = 1'b1;
    fetch_drive(1'b0, 32'd0);
    dma_drive(1'b0, 1'b0, 32'd0, 64'd0, 3'd0);
    step(); step(); step();
    rst = 1'b0;
    #1;
    check_val("rst_ready",  64'(dma_iccm_ready),     64'd1);
    check_val("rst_stall",  64'(dma_iccm_stall_any), 64'd0);
    check_val("rst_rvalid", 64'(dma_iccm_rvalid),    64'd0);
    check_val("rst_wren",   64'(iccm_wren),          64'd0);

    // Basic read, ICCM idle.
    step();
    dma_drive(1'b1, 1'b0, SADR + 32'h10, 64'd0, 3'd5);
    #1;
    check_val("rd_ready0", 64'(dma_iccm_ready), 64'd1);
    step();
    dma_drive(1'b0, 1'b0, 32'd0, 64'd0, 3'd0);
    #1;
    check_val("rd_rden", 64'(iccm_rden), 64'd1);
    check_val("rd_addr", 64'(iccm_addr), 64'd2);
    check_val("rd_wren", 64'(iccm_wren), 64'd0);
    step(); #1;
    check_val("rd_rvalid", 64'(dma_iccm_rvalid), 64'd1);
    check_val("rd_rtag",   64'(dma_iccm_rtag),   64'd5);
    check_val("rd_err",    64'(dma_iccm_err),    64'd0);
    check_val("rd_rdata",  dma_iccm_rdata,       64'hDA7A0000_00000002);
    step(); #1;
    check_val("rd_rvalid_off", 64'(dma_iccm_rvalid), 64'd0);

    // Starved write while fetch owns the ICCM.
    ifc_dma_access_ok = 1'b0;
    fetch_drive(1'b1, 32'hEE000100);
    dma_drive(1'b1, 1'b1, SADR + 32'h40, 64'h11223344_55667788, 3'd2);
    step();
    dma_drive(1'b0, 1'b0, 32'd0, 64'd0, 3'd0);
    #1;
    check_val("st_stall_p1", 64'(dma_iccm_stall_any), 64'd0);
    check_val("st_ready_p1", 64'(dma_iccm_ready),     64'd0);
    check_val("st_fetch_rden", 64'(iccm_rden), 64'd1);
    check_val("st_fetch_addr", 64'(iccm_addr), 64'h20);
    repeat (7) step();
    #1;
    check_val("st_stall_p8", 64'(dma_iccm_stall_any), 64'd0);
    step(); #1;
    check_val("st_stall_force", 64'(dma_iccm_stall_any), 64'd1);
    repeat (10) step();
    #1;
    check_val("st_stall_hold", 64'(dma_iccm_stall_any), 64'd1);
    check_val("st_wren_hold",  64'(iccm_wren),          64'd0);
    fetch_drive(1'b0, 32'd0);
    ifc_dma_access_ok = 1'b1;
    #1;
    check_val("st_wren",  64'(iccm_wren),  64'd1);
    check_val("st_rden",  64'(iccm_rden),  64'd0);
    check_val("st_waddr", 64'(iccm_addr),  64'd8);
    check_val("st_wdata", iccm_wdata,      64'h11223344_55667788);
    step(); #1;
    check_val("st_stall_drop", 64'(dma_iccm_stall_any), 64'd0);
    check_val("st_no_rsp",     64'(dma_iccm_rvalid),    64'd0);
    check_val("st_ready_end",  64'(dma_iccm_ready),     64'd1);

    // Error entries: out of range read, misaligned write; then last legal word.
    dma_drive(1'b1, 1'b0, SADR + 32'h10000, 64'd0, 3'd3);
    step();
    dma_drive(1'b1, 1'b1, SADR + 32'h14, 64'hABCD, 3'd6);
    #1;
    check_val("er1_rden", 64'(iccm_rden), 64'd0);
    check_val("er1_wren", 64'(iccm_wren), 64'd0);
    step();
    dma_drive(1'b1, 1'b0, SADR + 32'hFFF8, 64'd0, 3'd1);
    #1;
    check_val("er1_rvalid", 64'(dma_iccm_rvalid), 64'd1);
    check_val("er1_err",    64'(dma_iccm_err),    64'd1);
    check_val("er1_rdata",  dma_iccm_rdata,       64'd0);
    check_val("er1_rtag",   64'(dma_iccm_rtag),   64'd3);
    check_val("er2_wren",   64'(iccm_wren),       64'd0);
    step();
    dma_drive(1'b0, 1'b0, 32'd0, 64'd0, 3'd0);
    #1;
    check_val("er2_rvalid", 64'(dma_iccm_rvalid), 64'd1);
    check_val("er2_err",    64'(dma_iccm_err),    64'd1);
    check_val("er2_rtag",   64'(dma_iccm_rtag),   64'd6);
    check_val("top_rden",   64'(iccm_rden),       64'd1);
    check_val("top_addr",   64'(iccm_addr),       64'h1FFF);
    step(); #1;
    check_val("top_err",    64'(dma_iccm_err),    64'd0);
    check_val("top_rdata",  dma_iccm_rdata,       64'hDA7A0000_00001FFF);

    // Back-to-back reads: tags 1..4 to word idx 0..3.
    step();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) dma_drive(1'b1, 1'b0, SADR + 32'(8 * i), 64'd0, 3'(i + 1));
      else       dma_drive(1'b0, 1'b0, 32'd0, 64'd0, 3'd0);
      #1;
      check_val($sformatf("b2b_ready%0d", i), 64'(dma_iccm_ready), 64'd1);
      if (i >= 1 && i <= 4) begin
        check_val($sformatf("b2b_rden%0d", i), 64'(iccm_rden), 64'd1);
        check_val($sformatf("b2b_addr%0d", i), 64'(iccm_addr), 64'(i - 1));
      end
      if (i >= 2) begin
        check_val($sformatf("b2b_rvalid%0d", i), 64'(dma_iccm_rvalid), 64'd1);
        check_val($sformatf("b2b_rtag%0d", i),   64'(dma_iccm_rtag),   64'(i - 1));
        check_val($sformatf("b2b_rdata%0d", i),  dma_iccm_rdata,
                  64'hDA7A0000_00000000 + 64'(i - 2));
      end
      step();
    end

    // Reset the cycle after a read grant.
    dma_drive(1'b1, 1'b0, SADR + 32'h18, 64'd0, 3'd7);
    step();
    dma_drive(1'b0, 1'b0, 32'd0, 64'd0, 3'd0);
    #1;
    check_val("rs_rden", 64'(iccm_rden), 64'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_val("rs_rvalid", 64'(dma_iccm_rvalid),    64'd0);
    check_val("rs_ready",  64'(dma_iccm_ready),     64'd1);
    check_val("rs_stall",  64'(dma_iccm_stall_any), 64'd0);

    // Grant overlapping an active fetch.
    fetch_drive(1'b1, 32'hEE000180);
    dma_drive(1'b1, 1'b0, SADR + 32'h20, 64'd0, 3'd4);
    #1;
    check_val("ov_fetch_addr0", 64'(iccm_addr), 64'h30);
    check_val("ov_fetch_rden0", 64'(iccm_rden), 64'd1);
    step();
    dma_drive(1'b0, 1'b0, 32'd0, 64'd0, 3'd0);
    #1;
    check_val("ov_dma_rden", 64'(iccm_rden), 64'd1);
    check_val("ov_dma_addr", 64'(iccm_addr), 64'd4);
    step(); #1;
    check_val("ov_rvalid",      64'(dma_iccm_rvalid), 64'd1);
    check_val("ov_rtag",        64'(dma_iccm_rtag),   64'd4);
    check_val("ov_rdata",       dma_iccm_rdata,       64'hDA7A0000_00000004);
    check_val("ov_fetch_addr2", 64'(iccm_addr),       64'h30);
    fetch_drive(1'b0, 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
